operand_stage_buffer: RTL
=========================

Name: operand_stage_buffer

Overview:
- Parametrised pipeline operand register carrying NUM_OPS operands of WIDTH bits between decode/register-read and execute.
- Adds a valid/ready handshake, optional skid entry, synchronous flush and an occupancy report.
- One instance replaces the per-operand unconditional latches in front of the ALU operand muxes, so stalls and branch flushes are absorbed here.

Parameters:
- WIDTH, 32, bits per operand.
- NUM_OPS, 2, number of operands carried (for example rs1/rs2); must be at least 1.
- SKID, 1, 1 = two-entry skid buffer with in_ready from registered state only; 0 = single entry with in_ready combinational from out_ready.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous kill of all held and incoming operands.
- in_valid  input  1  upstream has operands.
- in_ready  output  1  buffer accepts this cycle.
- in_data  input  NUM_OPS*WIDTH  packed operands; operand k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  1  operands available to execute.
- out_ready  input  1  execute consumes this cycle.
- out_data  output  NUM_OPS*WIDTH  packed operands, same layout as in_data.
- occupancy  output  2  entries held (0..2; never exceeds 1 when SKID=0).

Behaviour:
- Handshake events:
  - Accept = in_valid & in_ready.
  - Release = out_valid & out_ready.
  - Latency in to out is 1 cycle; there is no combinational path from in_data to out_data.
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=0, skid entry cleared, occupancy=0, state EMPTY.
  - in_ready=1 once rst deasserts.
  - Reset mid-transfer discards all entries.
- SKID=1 state machine: EMPTY, ONE (main valid), TWO (main+skid valid). in_ready = (state != TWO).
  - EMPTY: accept -> main<=in_data, go to ONE.
  - ONE, accept & release -> main<=in_data, stay in ONE.
  - ONE, accept only -> skid<=in_data, go to TWO.
  - ONE, release only -> go to EMPTY.
  - TWO, release -> main<=skid, go to ONE. No accept is possible in TWO.
  - TWO, no release -> hold.
  - out_valid = (state != EMPTY); out_data always comes from main.
- SKID=0: single entry.
  - in_ready = !out_valid | out_ready.
  - Accept -> main<=in_data, out_valid<=1.
  - Release without accept -> out_valid<=0.
  - States used: EMPTY and ONE only.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
- Flush (synchronous, highest priority):
  - Next state EMPTY; out_valid<=0; main and skid data <=0; occupancy<=0.
  - An accept in the flush cycle is consumed (upstream sees the handshake) and dropped.
  - A release in the flush cycle completes normally (execute already took the data).
- Data stored in the main register when its valid is 0 is don't-care, except that reset and flush force it to zero.
- occupancy = 0/1/2 for EMPTY/ONE/TWO.
- Assertions (bench only):
  - in_data is stable while in_valid & !in_ready.
  - occupancy never reaches 2 when SKID=0.

Decomposition:
- Shared package holds:
  - buf_state_e enum {EMPTY, ONE, TWO} (2-bit).
  - OCC_W = 2.
- One sub-module: operand_slot, a WIDTH*NUM_OPS register with load enable and synchronous clear. It is instantiated for main and, under a generate on SKID, for skid.
- Control FSM and ready/valid logic stay in the top module.

Test Plan:
- Reset release, then in_valid=1, in_data={32'h0000_0002,32'h0000_0001}, out_ready=1 -> next cycle out_valid=1, out_data equals input, occupancy=1; in_ready stays 1.
- SKID=1, out_ready=0, present A then B -> A in main, B in skid, occupancy=2, in_ready=0; hold 3 cycles with out_data=A stable; out_ready=1 -> A released, then B next cycle; in_ready returns to 1 the cycle after the first release.
- SKID=1, streaming 8 beats with out_ready toggling 1,0,1,0 -> all 8 values arrive in order with no loss or duplication; occupancy never exceeds 2.
- Occupancy=2, assert flush together with in_valid=1 (data C) -> next cycle out_valid=0, occupancy=0, out_data=0; C never appears at the output.
- SKID=0, out_valid=1, out_ready=1, in_valid=1 with data D -> in_ready=1 in the same cycle; D is out next cycle with no bubble.
- Pull rst low asynchronously mid-cycle while occupancy=2 -> out_valid=0 and out_data=0 immediately (before the next clk edge); after release the first accepted beat appears with 1-cycle latency.

Source files
------------

// File: rtl/operand_stage_buffer_pkg.sv
// Shared types for the operand stage buffer: occupancy width and the
// buffer state encoding, which doubles as the occupancy count.
package operand_stage_buffer_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/operand_stage_buffer_slot.sv
// operand_slot: one packed operand entry with load enable and a synchronous
// clear that wins over load.
module operand_slot #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // NOTE: hold value assigned first so no path through this block can infer a latch.
    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (load) begin
            data_d = d;
        end
    end

    // NOTE: the data register is reset (not left undefined) because out_data must read zero out of reset;
    // state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/operand_stage_buffer.sv
// Operand register between register-read and execute: valid/ready handshake,
// optional skid entry, synchronous flush and occupancy report.
module operand_stage_buffer
    import operand_stage_buffer_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 2,
    parameter int SKID    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_OPS*WIDTH-1:0] out_data,
    output logic [OCC_W-1:0]         occupancy
);

    localparam int DW = NUM_OPS * WIDTH;

    buf_state_e    state_q;
    buf_state_e    state_d;
    logic          accept;
    logic          do_release;
    logic          main_load;
    logic          skid_load;
    logic          main_sel_skid;
    logic [DW-1:0] main_din;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;

    assign out_valid  = (state_q != EMPTY);
    // With a skid entry, ready depends only on registered state; without one it
    // must look through to out_ready to sustain full throughput.
    assign in_ready   = (SKID != 0) ? (state_q != TWO) : (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign do_release = out_valid && out_ready;

    always_comb begin
        state_d       = state_q;
        main_load     = 1'b0;
        skid_load     = 1'b0;
        main_sel_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_load = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (accept && do_release) begin
                    main_load = 1'b1;
                end else if (accept && (SKID != 0)) begin
                    skid_load = 1'b1;
                    state_d   = TWO;
                end else if (do_release) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (do_release) begin
                    main_load     = 1'b1;
                    main_sel_skid = 1'b1;
                    state_d       = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops held and incoming operands; the slots clear themselves.
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_din = main_sel_skid ? skid_q : in_data;

    operand_slot #(.W(DW)) u_main (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .load (main_load),
        .d    (main_din),
        .q    (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            operand_slot #(.W(DW)) u_skid (
                .clk  (clk),
                .rst  (rst),
                .clr  (flush),
                .load (skid_load),
                .d    (in_data),
                .q    (skid_q)
            );
        end else begin : g_no_skid
            assign skid_q = '0;
        end
    endgenerate

    assign out_data  = main_q;
    assign occupancy = OCC_W'(state_q);

endmodule
